// File: rtl/decode_arbiter.sv
// Round-robin arbiter that shares one decoder among NUM_REQ requesters, one transaction at a time.
// Optional watchdog: define DECODE_ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT cycles.

module decode_arbiter_lane (
  input  logic clock,
  input  logic reset,
  input  logic acc_hit,
  input  logic rsp_hit,
  output logic req_ready,
  output logic rsp_valid
);
  always_ff @(posedge clock) begin
    if (reset) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      req_ready <= acc_hit;
      rsp_valid <= rsp_hit;
    end
  end
endmodule

module decode_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int CODE_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*CODE_WIDTH-1:0] req_code,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          dec_start,
  output logic [CODE_WIDTH-1:0]         dec_code,
  input  logic [DATA_WIDTH-1:0]         dec_value,
  input  logic                          dec_ready,
  output logic                          busy
);
  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  if (NUM_REQ < 2 || TIMEOUT < 1) begin : g_bad_cfg
    $error("decode_arbiter: NUM_REQ must be >= 2 and TIMEOUT >= 1");
  end

  logic [1:0]    state;
  logic [IW-1:0] rr_ptr, grant, pick, rr_next;
  logic [IW:0]   scan;
  logic          found, accept, rsp_go, wd_expire;
  logic [NUM_REQ-1:0] acc_hit, rsp_hit;

  // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    scan  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (IW+1)'(k);
      if (scan >= (IW+1)'(NUM_REQ)) scan = scan - (IW+1)'(NUM_REQ);
      if (!found && req_valid[scan[IW-1:0]]) begin
        pick  = scan[IW-1:0];
        found = 1'b1;
      end
    end
  end

  assign rr_next = (grant == IW'(NUM_REQ-1)) ? '0 : grant + 1'b1;
  assign accept  = (state == S_IDLE) && found;
  assign rsp_go  = (state == S_WAIT) && (dec_ready || wd_expire);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign acc_hit[i] = accept && (pick == IW'(i));
    assign rsp_hit[i] = rsp_go && (grant == IW'(i));
    decode_arbiter_lane u_lane (
      .clock     (clock),
      .reset     (reset),
      .acc_hit   (acc_hit[i]),
      .rsp_hit   (rsp_hit[i]),
      .req_ready (req_ready[i]),
      .rsp_valid (rsp_valid[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      dec_start <= 1'b0;
      dec_code  <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            grant     <= pick;
            dec_code  <= req_code[pick*CODE_WIDTH +: CODE_WIDTH];
            dec_start <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        // dec_ready here may be a leftover from a transaction cut short by reset.
        S_ISSUE: begin
          dec_start <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (dec_ready) begin
            rsp_data <= dec_value;
            state    <= S_RESP;
          end else if (wd_expire) begin
            rsp_data <= '0;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          rr_ptr <= rr_next;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DECODE_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT-1);

  logic [TW-1:0] wdog;
  logic          err_q;

  assign wd_expire = (state == S_WAIT) && (wdog == WD_LAST);
  assign rsp_err   = err_q;

  // A dec_ready in the expiry cycle wins, so the error flag tracks !dec_ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_ISSUE)
        wdog <= '0;
      else if (state == S_WAIT && !rsp_go)
        wdog <= wdog + 1'b1;
      if (rsp_go)
        err_q <= !dec_ready;
      else if (state == S_RESP)
        err_q <= 1'b0;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_decode_arbiter.sv
// Directed bench for decode_arbiter: vector table plus hand-written corner sequences.

module tb_decode_arbiter;
  localparam int N   = 4;
  localparam int CW  = 8;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*CW-1:0] req_code;
  logic [N-1:0]  req_ready, rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err, dec_start, busy;
  logic [CW-1:0] dec_code;
  logic [DW-1:0] dec_value;
  logic          dec_ready;

  logic          stub_en = 1'b0;
  logic          stub_rdy = 1'b0;
  logic [DW-1:0] stub_val = '0;
  logic          frc_rdy = 1'b0;
  logic [DW-1:0] frc_val = '0;
  int            dly = 0;

  int checks = 0;
  int fails  = 0;

  assign dec_ready = stub_rdy | frc_rdy;
  assign dec_value = stub_rdy ? stub_val : frc_val;

  always #5 clock = ~clock;

  decode_arbiter #(.NUM_REQ(N), .CODE_WIDTH(CW), .DATA_WIDTH(DW), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_code(req_code),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dec_start(dec_start), .dec_code(dec_code), .dec_value(dec_value),
    .dec_ready(dec_ready), .busy(busy)
  );

  // Decoder stub: pulses dec_ready LAT cycles after it sees dec_start.
  always @(negedge clock) begin
    stub_rdy = 1'b0;
    if (!stub_en) dly = 0;
    else if (dec_start) dly = LAT;
    else if (dly > 0) begin
      dly--;
      if (dly == 0) stub_rdy = 1'b1;
    end
  end

  typedef struct {
    logic [N-1:0]    rv;
    logic [N*CW-1:0] codes;
    logic [DW-1:0]   val;
    logic [N-1:0]    exp_rdy;
    logic [CW-1:0]   exp_code;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin @(negedge clock); n++; end while (req_ready == '0 && n < 50);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin @(negedge clock); n++; end while (rsp_valid == '0 && n < 50);
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b1;
    repeat (cyc) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  int n, m, seen;
  int rr_seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    vt[0] = '{4'b0100, 32'h13252011, 32'hDEADBEEF, 4'b0100, 8'h25};
    vt[1] = '{4'b0011, 32'h0F0E0D0C, 32'h00000001, 4'b0001, 8'h0C};
    vt[2] = '{4'b1001, 32'h3C3B3A39, 32'h80000000, 4'b1000, 8'h3C};
    vt[3] = '{4'b1110, 32'h77665544, 32'h12345678, 4'b0010, 8'h55};
    vt[4] = '{4'b0001, 32'hFFEEDDCC, 32'hFFFFFFFF, 4'b0001, 8'hCC};
    vt[5] = '{4'b1111, 32'h04030201, 32'h00000000, 4'b0010, 8'h02};
    vt[6] = '{4'b0010, 32'hAAAA99AA, 32'h5A5AA5A5, 4'b0010, 8'h99};
    vt[7] = '{4'b1000, 32'hE1000000, 32'h0BADF00D, 4'b1000, 8'hE1};

    // Reset with all requesters valid, then fairness straight out of reset.
    reset = 1'b1; req_valid = 4'b1111; req_code = 32'h44332211; stub_val = 32'h00C0FFEE;
    stub_en = 1'b1;
    @(negedge clock); @(negedge clock);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_dec_start", dec_start, 0);
    chk("rst_dec_code", dec_code, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    for (int g = 0; g < 5; g++) begin
      wait_ready(n);
      chk(g == 0 ? "rr_first_latency" : "rr_back_to_back_gap", n, g == 0 ? 1 : 2);
      chk("rr_grant", req_ready, 4'b1 << rr_seq[g]);
      chk("rr_dec_code", dec_code, 8'h11 * (rr_seq[g] + 1));
      wait_rsp(m);
      chk("rr_rsp_valid", rsp_valid, 4'b1 << rr_seq[g]);
    end
    req_valid = '0;
    do_reset(1);

    // Table: rr_ptr starts at 0, each vector's grant computed by hand.
    for (int v = 0; v < 8; v++) begin
      req_valid = vt[v].rv; req_code = vt[v].codes; stub_val = vt[v].val;
      wait_ready(n);
      chk("tv_accept_latency", n, 1);
      chk("tv_req_ready", req_ready, vt[v].exp_rdy);
      chk("tv_dec_code", dec_code, vt[v].exp_code);
      chk("tv_dec_start", dec_start, 1);
      chk("tv_busy", busy, 1);
      req_valid = req_valid & ~req_ready;
      wait_rsp(m);
      chk("tv_rsp_latency", m, LAT + 1);
      chk("tv_rsp_valid", rsp_valid, vt[v].exp_rdy);
      chk("tv_rsp_data", rsp_data, vt[v].val);
      chk("tv_rsp_err", rsp_err, 0);
      req_valid = '0;
      @(negedge clock);
      chk("tv_idle_rsp_valid", rsp_valid, 0);
      chk("tv_rsp_data_hold", rsp_data, vt[v].val);
      chk("tv_idle_busy", busy, 0);
    end

    // Stray dec_ready in IDLE and in ISSUE.
    stub_en = 1'b0;
    frc_rdy = 1'b1; frc_val = 32'hBAD0BAD0;
    @(negedge clock);
    frc_rdy = 1'b0;
    chk("stray_idle_rsp", rsp_valid, 0);
    chk("stray_idle_busy", busy, 0);
    chk("stray_idle_data", rsp_data, 32'h0BADF00D);
    req_valid = 4'b0010; req_code = 32'h00006600;
    wait_ready(n);
    chk("stray_grant", req_ready, 4'b0010);
    frc_rdy = 1'b1;
    @(negedge clock);
    frc_rdy = 1'b0; req_valid = '0;
    chk("stray_issue_rsp", rsp_valid, 0);
    chk("stray_issue_busy", busy, 1);
    chk("stray_dec_start_low", dec_start, 0);
    chk("stray_dec_code_held", dec_code, 8'h66);
    @(negedge clock);
    chk("stray_still_waiting", rsp_valid, 0);
    frc_rdy = 1'b1; frc_val = 32'hCAFEF00D;
    @(negedge clock);
    frc_rdy = 1'b0;
    chk("stray_real_rsp", rsp_valid, 4'b0010);
    chk("stray_real_data", rsp_data, 32'hCAFEF00D);
    @(negedge clock);

    // Reset while in WAIT, then a late dec_ready.
    req_valid = 4'b1000; req_code = 32'h77000000;
    wait_ready(n);
    chk("midrst_grant", req_ready, 4'b1000);
    req_valid = '0;
    @(negedge clock);
    do_reset(1);
    chk("midrst_busy", busy, 0);
    chk("midrst_dec_code", dec_code, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    frc_rdy = 1'b1; frc_val = 32'h11112222;
    @(negedge clock);
    frc_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("midrst_no_rsp", {busy, rsp_valid}, 0);
      @(negedge clock);
    end

    // Decoder that never answers.
    req_valid = 4'b0001; req_code = 32'h0000005E;
    wait_ready(n);
    chk("wd_grant", req_ready, 4'b0001);
    req_valid = '0;
`ifdef DECODE_ARB_TIMEOUT_EN
    wait_rsp(m);
    chk("wd_latency", m, 16);
    chk("wd_rsp_valid", rsp_valid, 4'b0001);
    chk("wd_rsp_err", rsp_err, 1);
    chk("wd_rsp_data", rsp_data, 0);
`else
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (rsp_valid != '0) seen++;
    end
    chk("wd_off_busy", busy, 1);
    chk("wd_off_no_rsp", seen, 0);
    chk("wd_off_err", rsp_err, 0);
`endif
    do_reset(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/decode_arbiter.md
# decode_arbiter

Shares one `decoder_type_2` instance (and, through it, the key-value and state-variable memories) among NUM_REQ independent requesters. It accepts decode requests, grants one at a time in round-robin order, and drives the decoder's start/code inputs. It then waits for the decoder's `data_ready` pulse and returns the captured value to the granted requester. It sits between the protocol control logic and the single decoder/memory pair.

## Interface
- NUM_REQ, 4, number of requesters; must be ≥2.
- CODE_WIDTH, 8, width of a decode code; equals the decoder's CODE_WIDTH.
- DATA_WIDTH, 32, width of a decoded value; equals the decoder's DATA_WIDTH.
- TIMEOUT, 15, watchdog limit in cycles; used only with DECODE_ARB_TIMEOUT_EN.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held high until the matching req_ready pulse.
- req_code  in  NUM_REQ*CODE_WIDTH  request codes; requester i uses bits [i*CODE_WIDTH +: CODE_WIDTH]; held stable while req_valid is high.
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot.
- rsp_valid  out  NUM_REQ  one-cycle response pulse, one-hot, to the granted requester.
- rsp_data  out  DATA_WIDTH  response value; valid while rsp_valid is nonzero; holds its last value otherwise.
- rsp_err  out  1  timeout flag qualifying rsp_valid; tied 0 without DECODE_ARB_TIMEOUT_EN.
- dec_start  out  1  to decoder `decode_start`.
- dec_code  out  CODE_WIDTH  to decoder `inp_code`.
- dec_value  in  DATA_WIDTH  from decoder `out_value`.
- dec_ready  in  1  from decoder `data_ready`.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP. Encoding is a 2-bit register.
- **IDLE:**
  - Any req_valid bit set → grant the first set bit at or after `rr_ptr`, scanning upward with wrap.
  - On the grant: latch the grant index and that requester's code into dec_code, set req_ready[grant] for the next cycle, then go to ISSUE.
  - No request → stay in IDLE.
- **ISSUE (one cycle):**
  - dec_start=1, req_ready[grant]=1, dec_code stable. Go to WAIT.
  - dec_ready is ignored in this state, because a stale pulse can arrive from a reset-interrupted transaction.
- **WAIT:**
  - dec_start=0 and dec_code held.
  - dec_ready=1 → capture dec_value into rsp_data, then go to RESP.
- **RESP (one cycle):**
  - rsp_valid[grant]=1.
  - rr_ptr ← (grant+1) mod NUM_REQ.
  - dec_code is held through RESP, then go to IDLE.
- **Ordering:** one transaction in flight at a time. A requester whose req_valid is still high after its response is re-arbitrated as a new request.
- **dec_ready in IDLE or RESP:** ignored.
- **Reset:**
  - state=IDLE, rr_ptr=0, and all outputs 0: req_ready, rsp_valid, rsp_data, rsp_err, dec_start, dec_code, busy.
  - An in-flight transaction is dropped and gets no response; the requester must re-request.

## Timing
- Accept latency: req_valid sampled high in IDLE at edge N → req_ready and dec_start high during cycle N+1.
- Response latency: dec_ready sampled high at edge M in WAIT → rsp_valid high during cycle M+1.
- Minimum occupancy per transaction is 4 cycles plus the decoder latency. With MEM_DELAY=2, the decoder returns dec_ready a fixed number of cycles after dec_start, which the bench measures.
- Back-to-back: the next grant can be decided in the IDLE cycle that directly follows RESP.
- All outputs are registered, with no combinational path from input to output.
- Fairness: with all requesters continuously valid, the grant order is 0,1,2,3,0,…

## Configuration
- **DECODE_ARB_TIMEOUT_EN defined:**
  - A counter of width clog2(TIMEOUT+1) clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without dec_ready: go to RESP with rsp_data=0 and rsp_err=1.
  - A dec_ready arriving in the same cycle as the timeout wins, giving rsp_err=0.
- **Not defined:** no counter; WAIT lasts indefinitely; rsp_err is constant 0.

## Test plan
- **Reset:** assert reset 2 cycles with req_valid=4'b1111 → all outputs 0 and busy=0; the first grant after reset release goes to requester 0.
- **Single request:** req 2 with code 8'h25 and a decoder stub returning 32'hDEADBEEF → req_ready=4'b0100 pulse, dec_code=8'h25, then rsp_valid=4'b0100 with rsp_data=32'hDEADBEEF.
- **Round-robin:** all four requesters continuously valid → grants 0,1,2,3,0; no requester is granted twice before all others.
- **Stray ready:** dec_ready pulse in IDLE and in ISSUE → no rsp_valid and no state change; the genuine response is still returned correctly.
- **Reset mid-WAIT:** then a late dec_ready pulse → no rsp_valid; state stays IDLE.
- **Watchdog (DECODE_ARB_TIMEOUT_EN, TIMEOUT=15):** stub never asserts dec_ready → after 15 WAIT cycles, rsp_valid pulses with rsp_err=1 and rsp_data=0. Without the macro, busy stays high.
